uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of `uart_tx`: deserializes an asynchronous 8N1 line into bytes. It runs directly on the board crystal clock and needs no external bit-rate strobe. Received bytes are presented through a one-entry valid/ready holding register, and framing and overrun errors are flagged. It sits between the `rx` pin and whatever consumes characters, for example an echo path back into `uart_tx`.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx_sync2.sv | 39 +++
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared constants for the UART receive path: FSM state
//            encodings, data width and the default bit divider.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  // Payload width of one 8N1 character.
  localparam int c_data_bits = 8;

  // 27 MHz crystal / 115200 baud. The integer result is 234. The top-level
  // clkdiv instance uses the same value.
  localparam int c_default_clks_per_bit = 27_000_000 / 115200;

  // Receiver FSM encoding.
  localparam int c_state_w = 3;
  localparam logic [c_state_w-1:0] c_st_idle  = 3'd0;
  localparam logic [c_state_w-1:0] c_st_start = 3'd1;
  localparam logic [c_state_w-1:0] c_st_data  = 3'd2;
  localparam logic [c_state_w-1:0] c_st_stop  = 3'd3;
  localparam logic [c_state_w-1:0] c_st_break = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Byte-stream interface between the UART receiver and its
//            consumer. It carries a valid/ready handshake and two error
//            strobes.
// Signals  : data      - received byte, meaningful while valid=1
//            valid     - holding register full
//            ready     - consumer accepts data when valid && ready
//            frame_err - one-cycle pulse, stop bit sampled low
//            overrun   - one-cycle pulse, good byte dropped (holder full)
// Modports : master (receiver side), slave (consumer side)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if
  import uart_rx_pkg::*;
();
  logic [c_data_bits-1:0] data;
  logic                   valid;
  logic                   ready;
  logic                   frame_err;
  logic                   overrun;

  modport master (output data, output valid, output frame_err, output overrun,
                  input ready);
  modport slave  (input data, input valid, input frame_err, input overrun,
                  output ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync2
// Purpose  : Two-flop synchronizer (sync2) for a single asynchronous input.
//            RESET_VAL sets the value both flops take in reset. Use the
//            input's idle level so a reset does not look like an edge. The
//            same block also serves the start button input.
// Ports    : clk - destination clock
//            rst - synchronous active-high reset
//            i_d - asynchronous input
//            o_q - synchronized output, two clk cycles behind i_d
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver running on the crystal clock. It samples
//            every bit at its midpoint, presents each received byte
//            through a one-entry valid/ready holding register, and flags
//            framing and overrun errors.
// Ports    : clk  - system clock
//            rst  - synchronous active-high reset
//            rx   - serial line (asynchronous, idles high)
//            busy - receiver is in any state other than IDLE
//            bus  - uart_rx_if.master: data/valid/ready, frame_err, overrun
// Params   : CLKS_PER_BIT - clk cycles per bit, must be >= 8
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_default_clks_per_bit
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  output logic      busy,
  uart_rx_if.master bus
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       c_idx_last  = 3'(c_data_bits - 1);

  logic                   w_rx_s;
  logic [c_state_w-1:0]   r_state;
  logic [c_state_w-1:0]   w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_bit_idx;
  logic [c_data_bits-1:0] r_shift;
  logic [c_data_bits-1:0] r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_half_tick;
  logic w_bit_tick;
  logic w_can_load;
  logic w_busy;
  logic w_cnt_clr;
  logic w_cnt_run;
  logic w_idx_clr;
  logic w_shift_en;
  logic w_stop_good;
  logic w_stop_bad;

  // The line idles high, so the synchronizer resets to 1. A reset then
  // cannot produce a false start edge.
  uart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  assign w_half_tick = (r_cnt == c_half_last);
  assign w_bit_tick  = (r_cnt == c_bit_last);
  // A byte can load when the holder is empty or is emptied in this same cycle.
  assign w_can_load  = !r_valid || bus.ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (!w_rx_s) w_state_nxt = c_st_start;
      // A start bit that is high again at mid-bit was a glitch.
      c_st_start: if (w_half_tick) w_state_nxt = w_rx_s ? c_st_idle : c_st_data;
      c_st_data:  if (w_bit_tick && (r_bit_idx == c_idx_last)) w_state_nxt = c_st_stop;
      // Leave at mid-stop-bit so a back-to-back start edge is not missed.
      c_st_stop:  if (w_bit_tick) w_state_nxt = w_rx_s ? c_st_idle : c_st_break;
      // Stay in BREAK until the line goes high, so a held-low line does not
      // decode as a stream of 0x00 frames.
      c_st_break: if (w_rx_s) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / datapath control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy      = (r_state != c_st_idle);
    w_cnt_clr   = 1'b0;
    w_cnt_run   = 1'b0;
    w_idx_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      c_st_start: begin
        if (w_half_tick) begin
          w_cnt_clr = 1'b1;
          w_idx_clr = 1'b1;
        end else begin
          w_cnt_run = 1'b1;
        end
      end
      c_st_data: begin
        if (w_bit_tick) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
        end else begin
          w_cnt_run = 1'b1;
        end
      end
      c_st_stop: begin
        if (w_bit_tick) begin
          w_cnt_clr   = 1'b1;
          w_stop_good = w_rx_s;
          w_stop_bad  = !w_rx_s;
        end else begin
          w_cnt_run = 1'b1;
        end
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, shift register, holding register and error strobes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_run) r_cnt <= r_cnt + CNT_W'(1);

      if (w_idx_clr)       r_bit_idx <= '0;
      else if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;

      // LSB arrives first. Shifting right puts it at bit 0 after 8 samples.
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[c_data_bits-1:1]};

      // The two strobes come from mutually exclusive stop-sample outcomes.
      // They can never be high in the same cycle.
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_stop_good && !w_can_load;

      if (w_stop_good && w_can_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy          = w_busy;
  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx with CLKS_PER_BIT=16. An ideal
//            8N1 line driver sends frames. A negedge monitor logs handshakes
//            and error pulses. The expected results come from frame-level
//            rules: a good frame delivers its byte if the holder can take it,
//            otherwise it overruns; a low stop bit gives one framing error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int LAT_EXP = 3 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic busy;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs every accepted byte and counts error pulses.
  logic [7:0] got_q[$];
  int   fe_cnt   = 0;
  int   ov_cnt   = 0;
  int   both_cnt = 0;
  int   rise_cyc = -1;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus.valid && bus.ready) got_q.push_back(bus.data);
    if (bus.frame_err) fe_cnt = fe_cnt + 1;
    if (bus.overrun)   ov_cnt = ov_cnt + 1;
    if (bus.frame_err && bus.overrun) both_cnt = both_cnt + 1;
    if (bus.valid && !prev_valid) rise_cyc = cyc;
    prev_valid = bus.valid;
  end

  int checks   = 0;
  int failures = 0;
  int start_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 8'hxx;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // The line is left at the stop-bit level when the task returns.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop_bit;
    wait_cycles(CPB);
  endtask

  initial begin
    int   base, fe0, ov0, n, lat, busy_cnt, gap;
    logic got_valid;
    logic [7:0] first_b;
    logic [7:0] bytes[$];

    bus.ready = 1'b0;
    wait_cycles(4);
    @(negedge clk);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_data",  32'(bus.data),  32'd0);
    check("rst_ferr",  32'(bus.frame_err), 32'd0);
    check("rst_ovr",   32'(bus.overrun), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(4);

    // Single byte: delivery and latency.
    bus.ready = 1'b1;
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h48, 1'b1);
    wait_cycles(20);
    lat = rise_cyc - start_cyc;
    check("b48_count", 32'(got_q.size() - base), 32'd1);
    check("b48_data",  32'(got_at(base)), 32'h48);
    check("b48_latency_ok", 32'((lat >= LAT_EXP - 1) && (lat <= LAT_EXP + 1)), 32'd1);
    check("b48_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("b48_ovr",  32'(ov_cnt - ov0), 32'd0);

    // "Hi\n" back-to-back; ready rises once the first byte is held.
    bus.ready = 1'b0;
    got_valid = 1'b0;
    base = got_q.size();
    fork
      begin
        send_frame(8'h48, 1'b1);
        send_frame(8'h69, 1'b1);
        send_frame(8'h0A, 1'b1);
      end
      begin
        for (int i = 0; i < 400 && !got_valid; i++) begin
          @(negedge clk);
          if (bus.valid) got_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.ready = 1'b1;
      end
    join
    wait_cycles(20);
    check("hi_valid_seen", 32'(got_valid), 32'd1);
    check("hi_count", 32'(got_q.size() - base), 32'd3);
    check("hi_b0", 32'(got_at(base)),     32'h48);
    check("hi_b1", 32'(got_at(base + 1)), 32'h69);
    check("hi_b2", 32'(got_at(base + 2)), 32'h0A);

    // A 5-cycle glitch is rejected at the mid-start sample.
    base = got_q.size(); fe0 = fe_cnt;
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) rx = 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    check("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
    check("glitch_count", 32'(got_q.size() - base), 32'd0);
    check("glitch_ferr",  32'(fe_cnt - fe0), 32'd0);

    // Low stop bit followed by a held-low line, then a clean frame.
    base = got_q.size(); fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    wait_cycles(48);
    @(negedge clk);
    check("brk_busy_held", 32'(busy), 32'd1);
    check("brk_ferr_once", 32'(fe_cnt - fe0), 32'd1);
    check("brk_no_valid",  32'(bus.valid), 32'd0);
    @(posedge clk); #1;
    rx = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    check("brk_released", 32'(busy), 32'd0);
    wait_cycles(5);
    send_frame(8'h41, 1'b1);
    wait_cycles(20);
    check("brk_count",  32'(got_q.size() - base), 32'd1);
    check("brk_b41",    32'(got_at(base)), 32'h41);
    check("brk_ferr_total", 32'(fe_cnt - fe0), 32'd1);

    // Overrun: with ready low, only the first of n frames is kept.
    bus.ready = 1'b0;
    base = got_q.size(); ov0 = ov_cnt;
    n = $urandom_range(2, 4);
    bytes.delete();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
    first_b = bytes[0];
    for (int i = 0; i < n; i++) send_frame(bytes[i], 1'b1);
    wait_cycles(20);
    @(negedge clk);
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'(n - 1));
    check("ovr_valid",  32'(bus.valid), 32'd1);
    check("ovr_data_kept", 32'(bus.data), 32'(first_b));
    check("ovr_none_taken", 32'(got_q.size() - base), 32'd0);
    @(posedge clk); #1;
    bus.ready = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    check("ovr_valid_drop", 32'(bus.valid), 32'd0);
    check("ovr_count", 32'(got_q.size() - base), 32'd1);
    check("ovr_first", 32'(got_at(base)), 32'(first_b));

    // Reset in the middle of data bit 3 of 0xA5; the driver stops the frame.
    base = got_q.size();
    first_b = 8'hA5;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = first_b[i];
      wait_cycles(CPB);
    end
    rx = first_b[3];
    wait_cycles(CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.valid), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_data",  32'(bus.data), 32'd0);
    check("mid_rst_ferr",  32'(bus.frame_err), 32'd0);
    check("mid_rst_ovr",   32'(bus.overrun), 32'd0);
    wait_cycles(10);
    send_frame(8'h5A, 1'b1);
    wait_cycles(20);
    check("mid_rst_count", 32'(got_q.size() - base), 32'd1);
    check("mid_rst_b5a",   32'(got_at(base)), 32'h5A);

    // Random bytes with random idle gaps, consumer always ready.
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    bytes.delete();
    for (int i = 0; i < 8; i++) begin
      bytes.push_back(8'($urandom));
      send_frame(bytes[i], 1'b1);
      gap = $urandom_range(0, 10);
      wait_cycles(gap);
    end
    wait_cycles(20);
    check("rnd_count", 32'(got_q.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rnd_b%0d", i), 32'(got_at(base + i)), 32'(bytes[i]));
    check("rnd_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("rnd_ovr",  32'(ov_cnt - ov0), 32'd0);
    check("never_both_err", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
